// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-keyboard PS/2 transmitter (open-collector host side).
//
// Sends one byte to the keyboard: inhibit (clock low), request-to-send
// (data low, clock released), then 10 device-clocked bits (8 data LSB first,
// odd parity, stop), then samples the device ack on the 11th falling edge.
//
// Ports:
//   c           system clock
//   reset       asynchronous active-high reset
//   tx_start    one-cycle request, accepted only while busy=0
//   tx_data     byte to send, latched on accepted tx_start
//   ps2_clk_in  raw PS/2 clock pin level (asynchronous)
//   ps2_dat_in  raw PS/2 data pin level (asynchronous)
//   ps2_clk_oe  1 = pull PS/2 clock low
//   ps2_dat_oe  1 = pull PS/2 data low
//   busy        transfer in progress
//   done        one-cycle pulse at end of transfer
//   err         one-cycle pulse with done when the transfer failed
//
// Optional feature: define PS2_HOST_TX_RETRY_EN to retry a NACKed or
// timed-out transfer up to twice before reporting the failure.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int TIMEOUT_CYCLES = 360000
) (
  input  logic       c,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE} state_t;

  localparam logic [18:0] INH_LAST = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] TO_LAST  = 19'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [1:0]  clk_sync, dat_sync;
  logic        clk_prev;
  logic [9:0]  shift;      // {stop, parity, data}, sent from bit 0 upward
  logic [3:0]  bit_cnt;
  logic [18:0] cnt;        // shared inhibit / timeout counter
  logic        dat_q;      // data drive held between device clock edges
  logic        nack;

  logic fall, line_idle, timeout, retry_ok;
  logic load, retry, bit_adv, set_nack, fall_clr;

  assign fall      = clk_prev & ~clk_sync[1];
  assign line_idle = clk_sync[1] & dat_sync[1];
  assign timeout   = (cnt == TO_LAST);
  assign busy      = (state != IDLE);

`ifdef PS2_HOST_TX_RETRY_EN
  logic [1:0] tries;
  assign retry_ok = (tries != 2'd2);
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    load       = 1'b0;
    retry      = 1'b0;
    bit_adv    = 1'b0;
    set_nack   = 1'b0;
    fall_clr   = 1'b0;
    case (state)
      IDLE: if (tx_start) begin
        load     = 1'b1;
        state_nx = INHIBIT;
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == INH_LAST) state_nx = START;
      end
      START: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        state_nx   = BITS;
      end
      BITS, ACK, WAIT_IDLE: begin
        if (state == BITS) ps2_dat_oe = dat_q;
        if (timeout) begin
          // Lines stay released (oe defaults); fail or retry right away.
          ps2_dat_oe = 1'b0;
          if (retry_ok) begin
            retry    = 1'b1;
            state_nx = INHIBIT;
          end else begin
            done     = 1'b1;
            err      = 1'b1;
            state_nx = IDLE;
          end
        end else if (state == BITS) begin
          if (fall) begin
            bit_adv  = 1'b1;
            fall_clr = 1'b1;
            if (bit_cnt == 4'd9) state_nx = ACK;
          end
        end else if (state == ACK) begin
          if (fall) begin
            set_nack = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end else if (line_idle) begin
          if (nack && retry_ok) begin
            retry    = 1'b1;
            state_nx = INHIBIT;
          end else begin
            done     = 1'b1;
            err      = nack;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge c or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      cnt      <= '0;
      dat_q    <= 1'b0;
      nack     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_prev <= clk_sync[1];
      state    <= state_nx;
      // Cleared on every state entry, on each bit edge, and parked in IDLE.
      if (state_nx != state || fall_clr || state == IDLE) cnt <= '0;
      else                                               cnt <= cnt + 19'd1;
      if (load) shift <= {1'b1, ~^tx_data, tx_data};
      if (load || retry) begin
        bit_cnt <= '0;
        nack    <= 1'b0;
      end
      if (state == START) dat_q <= 1'b1;   // start bit held until first fall
      if (bit_adv) begin
        dat_q   <= ~shift[bit_cnt];
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (set_nack) nack <= dat_sync[1];
    end
  end

`ifdef PS2_HOST_TX_RETRY_EN
  always_ff @(posedge c or posedge reset) begin
    if (reset)      tries <= '0;
    else if (load)  tries <= '0;
    else if (retry) tries <= tries + 2'd1;
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard model.
// Stimulus pushes the expected outcome of each transfer; the monitor pops and
// compares it whenever done pulses.
module tb_ps2_host_tx;
  localparam int TB_INH = 40;
  localparam int TB_TO  = 600;
  localparam int H      = 10;   // device clock half period in c cycles
`ifdef PS2_HOST_TX_RETRY_EN
  localparam int N_FAIL_INH = 3;
`else
  localparam int N_FAIL_INH = 1;
`endif
  localparam int M_ACK = 0, M_NACK = 1, M_SILENT = 2;

  typedef struct {
    logic [9:0] frame;
    logic       err;
    int         n_inh;
    bit         chk_frame;
  } exp_t;
  exp_t exp_q[$];

  logic       c = 1'b0, reset = 1'b1, tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       clk_line, dat_line;

  assign clk_line = ~ps2_clk_oe & dev_clk;
  assign dat_line = ~ps2_dat_oe & dev_dat;

  ps2_host_tx #(.INHIBIT_CYCLES(TB_INH), .TIMEOUT_CYCLES(TB_TO)) dut (
    .c(c), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .ps2_clk_in(clk_line), .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .done(done), .err(err)
  );

  always #5 c = ~c;

  int errors = 0, checks = 0, done_cnt = 0, n_push = 0;
  int dev_mode = M_ACK, dev_bit = -1;
  bit dev_active = 1'b0, saw_inh = 1'b0;
  logic [9:0] last_frame = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Keyboard model: clocks 10 bits, sampling data late in each low phase,
  // then acks (or not) on the 11th clock.
  task automatic dev_frame();
    logic [9:0] fr;
    fr = '0;
    dev_active = 1'b1;
    repeat (H) @(negedge c);
    for (int i = 0; i < 10; i++) begin
      dev_bit = i;
      dev_clk = 1'b0;
      repeat (H) @(negedge c);
      fr[i]   = dat_line;
      dev_clk = 1'b1;
      repeat (H) @(negedge c);
    end
    dev_bit    = -1;
    last_frame = fr;
    repeat (H/2) @(negedge c);
    if (dev_mode == M_ACK) dev_dat = 1'b0;
    repeat (H/2) @(negedge c);
    dev_clk = 1'b0;
    repeat (H) @(negedge c);
    dev_clk = 1'b1;
    repeat (2) @(negedge c);
    dev_dat    = 1'b1;
    dev_active = 1'b0;
  endtask

  initial begin : device
    forever begin
      @(negedge c);
      if (reset) saw_inh = 1'b0;
      else if (ps2_clk_oe) saw_inh = 1'b1;
      else if (saw_inh && !dat_line) begin
        saw_inh = 1'b0;
        if (dev_mode != M_SILENT) dev_frame();
      end
    end
  end

  // Monitor / scoreboard
  int   inh_run = 0, n_inh = 0;
  bit   post = 1'b0;
  exp_t e;
  always @(negedge c) begin
    if (reset) begin
      inh_run = 0;
      n_inh   = 0;
      post    = 1'b0;
    end else begin
      if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
      else if (inh_run != 0) begin
        chk("inhibit_len", inh_run, TB_INH);
        n_inh++;
        inh_run = 0;
      end
      if (post) begin
        chk("busy_after_done", busy, 1'b0);
        post = 1'b0;
      end
      if (err && !done) begin
        checks++;
        errors++;
        $display("FAIL err_without_done: err=1 done=0");
      end
      if (done) begin
        done_cnt++;
        post = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending transfer");
        end else begin
          e = exp_q.pop_front();
          chk("err", err, e.err);
          chk("inhibit_phases", n_inh, e.n_inh);
          chk("clk_oe_at_done", ps2_clk_oe, 1'b0);
          chk("dat_oe_at_done", ps2_dat_oe, 1'b0);
          if (e.chk_frame) chk("frame", last_frame, e.frame);
        end
        n_inh = 0;
      end
    end
  end

  task automatic wait_dev_idle();
    int k = 0;
    while (dev_active && k < 5000) begin @(negedge c); k++; end
    if (k >= 5000) chk("dev_idle_timeout", 1, 0);
  endtask

  task automatic send(input logic [7:0] d, input int mode, input logic [9:0] fr,
                      input logic e_err, input int ninh, input bit chkf,
                      input bit poke_busy, input bit poke_done);
    exp_t x;
    int   k;
    x.frame = fr; x.err = e_err; x.n_inh = ninh; x.chk_frame = chkf;
    exp_q.push_back(x);
    n_push++;
    dev_mode = mode;
    @(negedge c); tx_data = d; tx_start = 1'b1;
    @(negedge c); tx_start = 1'b0;
    k = 0;
    while (!done && k < 20000) begin
      @(negedge c); k++;
      if (poke_busy && k == 80) begin
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge c); tx_start = 1'b0; k++;
      end
    end
    if (k >= 20000) chk("done_timeout", 1, 0);
    if (poke_done) begin
      // request in the done cycle itself must be ignored
      tx_data = 8'hAA; tx_start = 1'b1;
      @(negedge c); tx_start = 1'b0;
    end
    wait_dev_idle();
    repeat (10) @(negedge c);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int k, n0;
    repeat (3) @(negedge c);
    chk("rst_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_dat_oe", ps2_dat_oe, 1'b0);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_done",   done, 1'b0);
    chk("rst_err",    err, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge c);

    send(8'hED, M_ACK,    10'h3ED, 1'b0, 1,          1'b1, 1'b0, 1'b0);
    send(8'h07, M_ACK,    10'h207, 1'b0, 1,          1'b1, 1'b0, 1'b0);
    send(8'h00, M_ACK,    10'h300, 1'b0, 1,          1'b1, 1'b0, 1'b1);
    send(8'hED, M_ACK,    10'h3ED, 1'b0, 1,          1'b1, 1'b1, 1'b0);
    send(8'hFF, M_NACK,   10'h3FF, 1'b1, N_FAIL_INH, 1'b1, 1'b0, 1'b0);
    send(8'h3C, M_SILENT, 10'h000, 1'b1, N_FAIL_INH, 1'b0, 1'b0, 1'b0);

    // reset in the middle of the data bits
    dev_mode = M_ACK;
    @(negedge c); tx_data = 8'hA5; tx_start = 1'b1;
    @(negedge c); tx_start = 1'b0;
    k = 0;
    while (dev_bit != 4 && k < 5000) begin @(negedge c); k++; end
    if (k >= 5000) chk("bit4_timeout", 1, 0);
    n0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_clk_oe", ps2_clk_oe, 1'b0);
    chk("rst_mid_dat_oe", ps2_dat_oe, 1'b0);
    chk("rst_mid_busy",   busy, 1'b0);
    @(negedge c); @(negedge c); reset = 1'b0;
    wait_dev_idle();
    repeat (20) @(negedge c);
    chk("no_done_after_reset", done_cnt, n0);

    send(8'hF3, M_ACK, 10'h3F3, 1'b0, 1, 1'b1, 1'b0, 1'b0);

    chk("done_count", done_cnt, n_push);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
